// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serializer.
// Frames leave LSB first and queued bytes go out back-to-back.
module uart_tx_fifo #(
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned SYS_CLK_FREQ = 12000000,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  localparam int unsigned CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned BIT_CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W        = PTR_W + 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo: SYS_CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count_d;
  logic                 push;
  logic                 pop;

  state_t               state_q;
  state_t               state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_d;
  logic [2:0]           bit_idx_q;
  logic [2:0]           bit_idx_d;
  logic [7:0]           shift_q;
  logic [7:0]           shift_d;
  logic                 bit_last;
  logic                 tx_d;
  logic                 busy_d;

  // Pushes are gated by the registered full flag, so a same-cycle pop never frees a slot.
  assign push     = wr_en & ~full;
  assign bit_last = (bit_cnt_q == BIT_CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    count_d = count;
    unique case ({push, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // FIFO pointers, occupancy and flags
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_d;
      full     <= (count_d == CNT_W'(FIFO_DEPTH));
      empty    <= (count_d == '0);
      overflow <= wr_en & full;
    end
  end

  // Storage needs no reset; occupancy alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Serializer state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx        <= tx_d;
      busy      <= busy_d;
    end
  end

  // Next state, pop decision and next line level
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_last ? '0 : bit_cnt_q + BIT_CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_d      = 1'b1;
    busy_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_last) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_last) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_last) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered so tx comes straight from a flop.
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a 16-clock-per-bit instance for the protocol
// scenarios and a default-parameter instance for the full-rate single byte.
module tb_uart_tx_fifo;

  logic       clk;
  logic       nrst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, busy, tx;
  logic [4:0] count;

  logic       wr_en_d;
  logic [7:0] wr_data_d;
  logic       full_d, empty_d, overflow_d, busy_d, tx_d;
  logic [4:0] count_d;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0, t1, t2, errs, busyc;

  uart_tx_fifo #(.BAUD_RATE(1), .SYS_CLK_FREQ(16), .FIFO_DEPTH(16)) dut (
    .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .busy(busy), .tx(tx)
  );

  uart_tx_fifo dut_def (
    .clk(clk), .nrst(nrst), .wr_en(wr_en_d), .wr_data(wr_data_d),
    .full(full_d), .empty(empty_d), .count(count_d), .overflow(overflow_d),
    .busy(busy_d), .tx(tx_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level of bit slot k of an 8N1 frame (0 = start, 1..8 = data LSB first, 9 = stop)
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[3'(k - 1)];
  endfunction

  // Checks every cycle of a 160-cycle frame on the small instance, starting at index 'first'.
  task automatic check_frame(input logic [7:0] d, input int first, input string tag);
    int e;
    e = 0;
    for (int j = first; j < 160; j++) begin
      if (j != first) tick(1);
      if (tx !== frame_bit(d, j / 16) || busy !== 1'b1) e++;
    end
    chk(tag, e, 0);
  endtask

  initial begin
    nrst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_en_d = 1'b0; wr_data_d = '0;
    #2 nrst = 1'b0;
    tick(2);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_def_tx", tx_d, 1);
    #2 nrst = 1'b1;
    tick(2);

    // Single byte timing
    wr_en = 1'b1; wr_data = 8'h55; tick(1); wr_en = 1'b0;
    chk("push_empty", empty, 0);
    chk("push_count", count, 1);
    chk("push_tx_still_idle", tx, 1);
    tick(1);
    chk("pop_count", count, 0);
    chk("pop_empty", empty, 1);
    check_frame(8'h55, 0, "frame_55");
    tick(1);
    chk("single_idle_tx", tx, 1);
    chk("single_idle_busy", busy, 0);

    // Back-to-back frames
    wr_en = 1'b1; wr_data = 8'h00; tick(1);
    wr_data = 8'hFF; tick(1); t0 = cyc;
    wr_data = 8'hA3; tick(1); wr_en = 1'b0;
    chk("b2b_count_peak", count, 2);
    check_frame(8'h00, 1, "b2b_frame_00");
    tick(1); t1 = cyc;
    check_frame(8'hFF, 0, "b2b_frame_ff");
    tick(1); t2 = cyc;
    check_frame(8'hA3, 0, "b2b_frame_a3");
    chk("b2b_spacing_1", t1 - t0, 160);
    chk("b2b_spacing_2", t2 - t1, 160);
    tick(1);
    chk("b2b_idle_tx", tx, 1);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_empty", empty, 1);

    // Fill while a dummy frame holds the line, then push at full during the pop
    wr_en = 1'b1; wr_data = 8'hFF; tick(1); wr_en = 1'b0;
    tick(1); t0 = cyc;
    chk("fill_dummy_start", tx, 0);
    for (int i = 1; i <= 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); tick(1);
      if (i == 16) begin
        chk("fill_full_at_16", full, 1);
        chk("fill_count_16", count, 16);
        chk("fill_no_ovf_16", overflow, 0);
      end
    end
    wr_en = 1'b0;
    chk("fill_ovf_17", overflow, 1);
    chk("fill_count_after_17", count, 16);
    tick(1);
    chk("fill_ovf_one_cycle", overflow, 0);
    while (cyc < t0 + 159) tick(1);
    wr_en = 1'b1; wr_data = 8'h99; tick(1); wr_en = 1'b0;
    chk("popfull_ovf", overflow, 1);
    chk("popfull_count", count, 15);
    chk("popfull_full", full, 0);
    check_frame(8'h01, 0, "fill_frame_01");
    for (int i = 2; i <= 16; i++) begin
      tick(1);
      check_frame(8'(i), 0, $sformatf("fill_frame_%0h", i));
    end
    tick(1);
    chk("fill_drained_tx", tx, 1);
    chk("fill_drained_busy", busy, 0);
    chk("fill_drained_empty", empty, 1);

    // Push landing on the final stop cycle
    wr_en = 1'b1; wr_data = 8'h5A; tick(1); wr_en = 1'b0;
    tick(1);
    check_frame(8'h5A, 0, "late_frame_5a");
    wr_en = 1'b1; wr_data = 8'h42; tick(1); wr_en = 1'b0;
    chk("late_gap_tx", tx, 1);
    chk("late_gap_busy", busy, 0);
    chk("late_gap_count", count, 1);
    tick(1);
    check_frame(8'h42, 0, "late_frame_42");
    tick(1);
    chk("late_idle_busy", busy, 0);

    // Reset in the middle of data bit 3
    wr_en = 1'b1; wr_data = 8'hC3; tick(1);
    wr_data = 8'h3C; tick(1); wr_en = 1'b0;
    tick(70);
    chk("mid_bit3_low", tx, 0);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    tick(3);
    #2 nrst = 1'b1;
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    chk("post_rst_quiet", errs, 0);
    wr_en = 1'b1; wr_data = 8'h7E; tick(1); wr_en = 1'b0;
    tick(1);
    check_frame(8'h7E, 0, "post_rst_frame_7e");
    tick(1);
    chk("post_rst_idle", busy, 0);

    // Default parameters: 1250 clocks per bit
    wr_en_d = 1'b1; wr_data_d = 8'h55; tick(1); wr_en_d = 1'b0;
    chk("def_push_busy", busy_d, 0);
    tick(1);
    errs = 0; busyc = 0;
    for (int j = 0; j < 12500; j++) begin
      if (j != 0) tick(1);
      if (tx_d !== frame_bit(8'h55, j / 1250)) errs++;
      if (busy_d === 1'b1) busyc++;
    end
    chk("def_frame_55", errs, 0);
    chk("def_busy_cycles", busyc, 12500);
    tick(1);
    chk("def_idle_tx", tx_d, 1);
    chk("def_idle_busy", busy_d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
